// File: rtl/count_chk_pkg.sv
// Shared definitions for the count stream checker: state encoding and counter sizing.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package count_chk_pkg;

   // State encoding is also driven out on the 2-bit state port.
   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'b00,
      ST_ACQUIRE  = 2'b01,
      ST_LOCKED   = 2'b10
   } state_t;

   // Bits needed for a counter that must be able to hold the value n.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/count_stream_checker_sat.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Latency: count updates on the edge after inc/clr; sat is decoded from the count register.
// Backpressure: none; increments at saturation are absorbed silently.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_count,
   output logic         o_sat
);

   logic [W-1:0] r_count;
   logic         w_full;

   assign w_full = &r_count;

   // Clear wins over increment; hold at all-ones once reached.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && !w_full) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
   // Sticky by construction: the count cannot leave all-ones except via clear/reset.
   assign o_sat   = w_full;

endmodule

// File: rtl/count_stream_checker.sv
// Locks onto a +1-per-sample counter stream, flywheels through mismatches, counts errors.
// Latency: 1 cycle; a sample taken at edge N is reflected in all outputs after edge N.
// Backpressure: none; every qualified sample is consumed, sample_valid=0 holds all state.
module count_stream_checker #(
   parameter int WIDTH      = 8,
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3,
   parameter int ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_sample_valid,
   input  logic [WIDTH-1:0] i_sample,
   input  logic             i_clear,
   output logic             o_locked,
   output logic             o_error_pulse,
   output logic [ERR_W-1:0] o_err_count,
   output logic             o_err_sat,
   output logic [1:0]       o_state
);
   import count_chk_pkg::*;

   localparam int MATCH_W = cnt_w(LOCK_COUNT);
   localparam int MISS_W  = cnt_w(LOSS_COUNT);
   // Compare against count-minus-one: the sample that completes the run is the one in flight.
   localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [MISS_W-1:0]  LOSS_LAST = MISS_W'(LOSS_COUNT - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_expected;
   logic [MATCH_W-1:0] r_match_cnt;
   logic [MISS_W-1:0]  r_miss_cnt;
   logic               r_error_pulse;

   state_t             w_state_nxt;
   logic [WIDTH-1:0]   w_expected_nxt;
   logic [MATCH_W-1:0] w_match_nxt;
   logic [MISS_W-1:0]  w_miss_nxt;
   logic               w_err;
   logic               w_hit;

   assign w_hit = (i_sample == r_expected);

   // State, predictor and run counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_UNLOCKED;
         r_expected    <= '0;
         r_match_cnt   <= '0;
         r_miss_cnt    <= '0;
         r_error_pulse <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_expected    <= w_expected_nxt;
         r_match_cnt   <= w_match_nxt;
         r_miss_cnt    <= w_miss_nxt;
         r_error_pulse <= w_err;
      end
   end

   // Next-state: seed/re-seed while acquiring, flywheel the prediction once locked.
   always_comb begin
      w_state_nxt    = r_state;
      w_expected_nxt = r_expected;
      w_match_nxt    = r_match_cnt;
      w_miss_nxt     = r_miss_cnt;
      w_err          = 1'b0;
      if (i_sample_valid) begin
         case (r_state)
            ST_UNLOCKED: begin
               w_expected_nxt = i_sample + 1'b1;
               w_match_nxt    = MATCH_W'(1);
               w_state_nxt    = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
               if (w_hit) begin
                  w_expected_nxt = r_expected + 1'b1;
                  if (r_match_cnt == LOCK_LAST) begin
                     w_match_nxt = '0;
                     w_miss_nxt  = '0;
                     w_state_nxt = ST_LOCKED;
                  end else begin
                     w_match_nxt = r_match_cnt + 1'b1;
                  end
               end else begin
                  w_expected_nxt = i_sample + 1'b1;
                  w_match_nxt    = MATCH_W'(1);
               end
            end
            ST_LOCKED: begin
               // Prediction advances on every sample, hit or miss.
               w_expected_nxt = r_expected + 1'b1;
               if (w_hit) begin
                  w_miss_nxt = '0;
               end else begin
                  w_err = 1'b1;
                  if (r_miss_cnt == LOSS_LAST) begin
                     w_miss_nxt  = '0;
                     w_state_nxt = ST_UNLOCKED;
                  end else begin
                     w_miss_nxt = r_miss_cnt + 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_UNLOCKED;
            end
         endcase
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_err),
      .i_clr   (i_clear),
      .o_count (o_err_count),
      .o_sat   (o_err_sat)
   );

   assign o_state       = r_state;
   assign o_locked      = (r_state == ST_LOCKED);
   assign o_error_pulse = r_error_pulse;

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed bench for count_stream_checker with a 2-bit error counter so saturation is reachable.
// Stimulus pushes hand-computed expected outputs; a monitor pops and compares one cycle later.
module tb_count_stream_checker;

   logic       clk;
   logic       rst_n;
   logic       sample_valid;
   logic [7:0] sample;
   logic       clear;
   logic       locked;
   logic       error_pulse;
   logic [1:0] err_count;
   logic       err_sat;
   logic [1:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string      name;
      logic [1:0] st;
      logic       p;
      logic [1:0] c;
      logic       s;
   } exp_t;

   exp_t exp_q[$];

   count_stream_checker #(
      .WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_sample_valid (sample_valid),
      .i_sample       (sample),
      .i_clear        (clear),
      .o_locked       (locked),
      .o_error_pulse  (error_pulse),
      .o_err_count    (err_count),
      .o_err_sat      (err_sat),
      .o_state        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed view {state, locked, pulse, count, sat}; locked follows the expected state.
   task automatic compare(input string name, input logic [1:0] st, input logic p,
                          input logic [1:0] c, input logic s);
      logic [6:0] act;
      logic [6:0] req;
      act = {state, locked, error_pulse, err_count, err_sat};
      req = {st, (st == 2'b10), p, c, s};
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got state=%b locked=%b pulse=%b cnt=%0d sat=%b, want state=%b locked=%b pulse=%b cnt=%0d sat=%b",
                  name, act[6:5], act[4], act[3], act[2:1], act[0],
                  req[6:5], req[4], req[3], req[2:1], req[0]);
      end
   endtask

   // Monitor: one expected entry per driven cycle, checked just after the capturing edge.
   always @(posedge clk) begin
      #1;
      if (rst_n && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         compare(e.name, e.st, e.p, e.c, e.s);
      end
   end

   task automatic step(input string name, input logic v, input logic [7:0] smp,
                       input logic clr, input logic [1:0] st, input logic p,
                       input logic [1:0] c, input logic s);
      exp_t e;
      @(negedge clk);
      sample_valid = v;
      sample       = smp;
      clear        = clr;
      e.name = name; e.st = st; e.p = p; e.c = c; e.s = s;
      exp_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      sample       = 8'h00;
      clear        = 1'b0;
      #12;
      compare("reset_asserted", 2'b00, 1'b0, 2'd0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      compare("reset_released", 2'b00, 1'b0, 2'd0, 1'b0);

      // Acquire and lock on 0x10..0x13.
      step("acq_10", 1, 8'h10, 0, 2'b01, 0, 2'd0, 0);
      step("acq_11", 1, 8'h11, 0, 2'b01, 0, 2'd0, 0);
      step("acq_12", 1, 8'h12, 0, 2'b01, 0, 2'd0, 0);
      step("lock_13", 1, 8'h13, 0, 2'b10, 0, 2'd0, 0);
      step("idle", 0, 8'h99, 0, 2'b10, 0, 2'd0, 0);

      // Single corrupted sample inside a locked stream.
      step("lk_14", 1, 8'h14, 0, 2'b10, 0, 2'd0, 0);
      step("lk_bad55", 1, 8'h55, 0, 2'b10, 1, 2'd1, 0);
      step("lk_16", 1, 8'h16, 0, 2'b10, 0, 2'd1, 0);
      step("clr1", 0, 8'h00, 1, 2'b10, 0, 2'd0, 0);

      // Stuck-at-zero bus: three errors then unlock, saturating on the third.
      step("stuck0_a", 1, 8'h00, 0, 2'b10, 1, 2'd1, 0);
      step("stuck0_b", 1, 8'h00, 0, 2'b10, 1, 2'd2, 0);
      step("stuck0_c", 1, 8'h00, 0, 2'b00, 1, 2'd3, 1);
      step("clr2", 0, 8'h00, 1, 2'b00, 0, 2'd0, 0);

      // Re-seed during acquisition, no errors counted outside lock.
      step("rs_05", 1, 8'h05, 0, 2'b01, 0, 2'd0, 0);
      step("rs_06", 1, 8'h06, 0, 2'b01, 0, 2'd0, 0);
      step("rs_40", 1, 8'h40, 0, 2'b01, 0, 2'd0, 0);
      step("rs_41", 1, 8'h41, 0, 2'b01, 0, 2'd0, 0);
      step("rs_42", 1, 8'h42, 0, 2'b01, 0, 2'd0, 0);
      step("rs_43", 1, 8'h43, 0, 2'b10, 0, 2'd0, 0);

      // Drop lock with a stuck bus, relock near the top, then wrap through 0xFF.
      step("drop_a", 1, 8'h00, 0, 2'b10, 1, 2'd1, 0);
      step("drop_b", 1, 8'h00, 0, 2'b10, 1, 2'd2, 0);
      step("drop_c", 1, 8'h00, 0, 2'b00, 1, 2'd3, 1);
      step("acq_fa", 1, 8'hFA, 0, 2'b01, 0, 2'd3, 1);
      step("acq_fb", 1, 8'hFB, 0, 2'b01, 0, 2'd3, 1);
      step("acq_fc", 1, 8'hFC, 0, 2'b01, 0, 2'd3, 1);
      step("lock_fd", 1, 8'hFD, 0, 2'b10, 0, 2'd3, 1);
      step("wrap_fe", 1, 8'hFE, 0, 2'b10, 0, 2'd3, 1);
      step("wrap_ff", 1, 8'hFF, 0, 2'b10, 0, 2'd3, 1);
      step("wrap_00", 1, 8'h00, 0, 2'b10, 0, 2'd3, 1);
      step("wrap_01", 1, 8'h01, 0, 2'b10, 0, 2'd3, 1);
      step("wrap_02", 1, 8'h02, 0, 2'b10, 0, 2'd3, 1);
      step("clr3", 0, 8'h00, 1, 2'b10, 0, 2'd0, 0);

      // Five locked errors (interleaved hits keep lock); clear coincides with the fifth.
      step("sat_e1", 1, 8'h77, 0, 2'b10, 1, 2'd1, 0);
      step("sat_e2", 1, 8'h77, 0, 2'b10, 1, 2'd2, 0);
      step("sat_h05", 1, 8'h05, 0, 2'b10, 0, 2'd2, 0);
      step("sat_e3", 1, 8'h77, 0, 2'b10, 1, 2'd3, 1);
      step("sat_e4", 1, 8'h77, 0, 2'b10, 1, 2'd3, 1);
      step("sat_h08", 1, 8'h08, 0, 2'b10, 0, 2'd3, 1);
      step("sat_e5_clr", 1, 8'h77, 1, 2'b10, 1, 2'd0, 0);
      step("sat_h0a", 1, 8'h0A, 0, 2'b10, 0, 2'd0, 0);
      step("pre_rst_err", 1, 8'h55, 0, 2'b10, 1, 2'd1, 0);

      // Asynchronous reset between edges must clear outputs without a clock.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      compare("async_reset", 2'b00, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      sample_valid = 1'b0;
      clear        = 1'b0;
      rst_n        = 1'b1;
      step("post_rst_30", 1, 8'h30, 0, 2'b01, 0, 2'd0, 0);
      step("post_rst_idle", 0, 8'h00, 0, 2'b01, 0, 2'd0, 0);

      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
